// File: rtl/mout_pkg.sv
// rtl/mout_pkg.sv - shared op codes, FSM encoding and widths for the Mout accumulate buffer
// Purpose: constants and types imported by mout_res_fifo and mout_acc_buffer.
// Ports: none (package).
package mout_pkg;

  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_DOT  = 3'b010;
  localparam logic [2:0] OP_CPLX = 3'b100;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam int DATA_W = 64;
  localparam int LANE_W = 32;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [2:0]        op_t;

  function automatic logic is_acc_op(input op_t op);
    return (op == OP_DOT) || (op == OP_CPLX);
  endfunction

endpackage

// File: rtl/mout_res_fifo.sv
// rtl/mout_res_fifo.sv - result FIFO holding {op, data} entries
// Purpose: DEPTH-entry synchronous FIFO; head outputs hold the last popped value while empty.
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   clr                synchronous flush (priority over push/pop)
//   push, push_op/data write port (caller never pushes when full)
//   pop                remove head (ignored when empty)
//   full, empty, count occupancy status
//   head_op, head_data current head (or last popped entry when empty)
module mout_res_fifo
  import mout_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          push,
  input  op_t           push_op,
  input  data_t         push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output op_t           head_op,
  output data_t         head_data
);

  op_t          mem_op   [DEPTH];
  data_t        mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  op_t           hold_op;
  data_t         hold_data;

  logic do_push;
  logic do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // When empty the head port shows the entry that was last popped
  assign head_op   = empty ? hold_op   : mem_op[rd_ptr];
  assign head_data = empty ? hold_data : mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem_op[wr_ptr]   <= push_op;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      hold_op   <= '0;
      hold_data <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      hold_op   <= '0;
      hold_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_op   <= mem_op[rd_ptr];
        hold_data <= mem_data[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mout_acc_buffer.sv
// rtl/mout_acc_buffer.sv - accumulate DOT/CPLX result groups, pass MUL, buffer into a result FIFO
// Purpose: downstream stage of the arithmetic unit consuming 64-bit Mout beats.
// Optional feature: define MOUT_ACC_SAT_EN to saturate DOT (64-bit) and CPLX (per 32-bit lane) sums.
// Ports:
//   clk, n_rst                   clock, asynchronous active-low reset
//   clr                          synchronous flush of FIFO, accumulator and err_op
//   in_valid/in_ready            input handshake; in_op, in_mout, in_last beat payload
//   out_valid/out_ready          output handshake; out_data, out_op head result
//   count                        FIFO occupancy
//   err_op                       sticky illegal-op / op-change-mid-group flag
module mout_acc_buffer
  import mout_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [63:0]   in_mout,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic [2:0]    out_op,
  output logic [AW:0]   count,
  output logic          err_op
);

  function automatic data_t dot_add(input data_t a, input data_t b);
    data_t s;
    s = a + b;
`ifdef MOUT_ACC_SAT_EN
    if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
      s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return s;
  endfunction

  function automatic lane_t lane_add(input lane_t a, input lane_t b);
    lane_t s;
    s = a + b;
`ifdef MOUT_ACC_SAT_EN
    if ((a[LANE_W-1] == b[LANE_W-1]) && (s[LANE_W-1] != a[LANE_W-1]))
      s = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
`endif
    return s;
  endfunction

  logic [0:0] state;
  data_t      acc;
  op_t        grp_op;
  logic       err;

  logic  full;
  logic  empty;
  logic  beat;
  logic  cont;
  logic  push;
  data_t push_data;
  data_t sum;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign err_op    = err;
  assign beat      = in_valid && in_ready && !clr;
  // Beat extends the open group only when the op matches the latched group op
  assign cont      = (state == ST_ACC) && (in_op == grp_op);

  // CPLX lanes are added separately so no carry crosses from imag into real
  assign sum = (in_op == OP_DOT) ? dot_add(acc, in_mout)
             : {lane_add(acc[63:32], in_mout[63:32]), lane_add(acc[31:0], in_mout[31:0])};

  always_comb begin
    push      = 1'b0;
    push_data = in_mout;
    if (beat) begin
      if (in_op == OP_MUL) begin
        push = 1'b1;
      end else if (is_acc_op(in_op) && in_last) begin
        push = 1'b1;
        if (cont) push_data = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      grp_op <= '0;
      err    <= 1'b0;
    end else if (clr) begin
      state  <= ST_IDLE;
      acc    <= '0;
      grp_op <= '0;
      err    <= 1'b0;
    end else if (beat) begin
      if (is_acc_op(in_op)) begin
        // Op change mid-group drops the partial sum and restarts from this beat
        if (state == ST_ACC && !cont) err <= 1'b1;
        if (in_last) begin
          state <= ST_IDLE;
          acc   <= '0;
        end else begin
          state  <= ST_ACC;
          acc    <= cont ? sum : in_mout;
          grp_op <= in_op;
        end
      end else if (in_op != OP_MUL) begin
        err <= 1'b1;
      end
    end
  end

  mout_res_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (clr),
    .push      (push),
    .push_op   (in_op),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head_op   (out_op),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_mout_acc_buffer.sv
// tb/tb_mout_acc_buffer.sv - directed self-checking bench for mout_acc_buffer
module tb_mout_acc_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_mout;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_op;
  logic [2:0]  count;
  logic        err_op;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_ovf;

  mout_acc_buffer #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_mout   (in_mout),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .count     (count),
    .err_op    (err_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait)
  task automatic send(input logic [2:0] op, input logic [63:0] data, input logic last);
    int n;
    in_op    = op;
    in_mout  = data;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_op = 3'b000;
    in_mout = '0; in_last = 1'b0; out_ready = 1'b1;
`ifdef MOUT_ACC_SAT_EN
    exp_ovf = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp_ovf = 64'h8000_0000_0000_0000;
`endif
    repeat (2) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_err_op", 64'(err_op), 64'd0);
    n_rst = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // MUL pass-through
    send(3'b001, 64'h0000_0000_0003_FC01, 1'b0);
    chk("mul_valid", 64'(out_valid), 64'd1);
    chk("mul_data", out_data, 64'h3FC01);
    chk("mul_op", 64'(out_op), 64'd1);
    step();
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_hold", out_data, 64'h3FC01);

    // DOT group of three
    send(3'b010, 64'h440, 1'b0);
    chk("dot_b1_novalid", 64'(out_valid), 64'd0);
    send(3'b010, 64'h10, 1'b0);
    chk("dot_b2_novalid", 64'(out_valid), 64'd0);
    send(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("dot_valid", 64'(out_valid), 64'd1);
    chk("dot_data", out_data, 64'h44F);
    chk("dot_op", 64'(out_op), 64'd2);
    step();

    // CPLX lanes wrap independently
    send(3'b100, 64'h0102_6000_FFFC_C000, 1'b0);
    send(3'b100, 64'hFEFD_A000_0003_4000, 1'b1);
    chk("cplx_valid", 64'(out_valid), 64'd1);
    chk("cplx_data", out_data, 64'h0);
    chk("cplx_op", 64'(out_op), 64'd4);
    step();

    // DOT overflow
    send(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    send(3'b010, 64'h1, 1'b1);
    chk("ovf_data", out_data, exp_ovf);
    step();

    // Fill FIFO and hold a fifth beat
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(3'b001, 64'(k), 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_op = 3'b001; in_mout = 64'd5; in_valid = 1'b1;
    step();
    chk("full_held_count", 64'(count), 64'd4);
    chk("fifo_out1", out_data, 64'd1);
    out_ready = 1'b1;
    step();
    chk("pop_in_ready", 64'(in_ready), 64'd1);
    chk("pop_count", 64'(count), 64'd3);
    chk("fifo_out2", out_data, 64'd2);
    step();
    in_valid = 1'b0;
    chk("pushpop_count", 64'(count), 64'd3);
    chk("fifo_out3", out_data, 64'd3);
    step();
    chk("fifo_out4", out_data, 64'd4);
    step();
    chk("fifo_out5", out_data, 64'd5);
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Illegal op dropped, then clr clears err_op
    send(3'b011, 64'hDEAD, 1'b1);
    chk("illegal_err", 64'(err_op), 64'd1);
    chk("illegal_dropped", 64'(out_valid), 64'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_err", 64'(err_op), 64'd0);

    // Op change mid-group
    send(3'b010, 64'h100, 1'b0);
    send(3'b100, 64'h0000_0005_0000_0007, 1'b0);
    chk("mismatch_err", 64'(err_op), 64'd1);
    chk("mismatch_novalid", 64'(out_valid), 64'd0);
    send(3'b100, 64'h0000_0001_0000_0001, 1'b1);
    chk("mismatch_data", out_data, 64'h0000_0006_0000_0008);
    chk("mismatch_op", 64'(out_op), 64'd4);
    step();

    // Reset mid-group with a pending entry
    out_ready = 1'b0;
    send(3'b010, 64'h123, 1'b0);
    send(3'b001, 64'h77, 1'b0);
    n_rst = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_data", out_data, 64'd0);
    chk("mrst_op", 64'(out_op), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_err", 64'(err_op), 64'd0);
    step();
    n_rst = 1'b1;
    out_ready = 1'b1;
    step();
    send(3'b010, 64'h5, 1'b0);
    send(3'b010, 64'h6, 1'b1);
    chk("post_rst_data", out_data, 64'hB);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
